rf_param_sweep: RTL and testbench
=================================

Name: rf_param_sweep

Overview:
- Parametrised successor to the RAT CPU register file.
- Configurable data width and depth; two asynchronous read ports and one synchronous write port.
- Optional write-to-read bypass and an optional hard-wired-zero entry 0.
- Hardware clear sequencer wipes every entry to 0 after reset or on command, one entry per clock, and reports BUSY until done.

Parameters:
- DATA_W, 8, width of each register entry in bits.
- DEPTH, 32, number of entries; any value from 2 to 256, not restricted to powers of two.
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH.
- BYPASS, 0, 1 = a same-cycle write is forwarded combinationally to a matching read port.
- ZERO_R0, 0, 1 = entry 0 always reads 0 and writes to it are discarded.

Ports:
- RF_CLK  in  1  rising-edge clock.
- RF_RST  in  1  synchronous, active-high reset.
- RF_CLR  in  1  single-cycle request to start a clear sweep.
- RF_ADDRX  in  ADDR_W  read address, port X.
- RF_ADDRY  in  ADDR_W  read address, port Y.
- RF_ADDR_WR  in  ADDR_W  write address.
- RF_WR  in  1  write enable.
- RF_DIN  in  DATA_W  write data.
- RF_DX_OUT  out  DATA_W  read data, port X (combinational).
- RF_DY_OUT  out  DATA_W  read data, port Y (combinational).
- RF_BUSY  out  1  high while a clear sweep is in progress.

Behaviour:
- Reset:
  - Sampled at RF_CLK rising edge when RF_RST=1: state <= CLEAR, sweep index <= 0, RF_BUSY=1.
  - While RF_RST is held, the index stays at 0 and no entries are written.
  - An RF_RST that arrives mid-sweep restarts the sweep at index 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on RF_CLR=1 (index <= 0).
  - CLEAR: each edge writes 0 to entry[index] and increments index. After the edge that writes entry DEPTH-1, state returns to IDLE.
  - A sweep takes exactly DEPTH cycles after RF_RST deasserts or after the RF_CLR edge. RF_BUSY drops in the cycle after the last entry is cleared.
  - RF_CLR while in CLEAR is ignored; the sweep does not restart.
- RF_BUSY: combinational decode, state==CLEAR. It is 1 out of reset.
- Write path:
  - In IDLE, with RF_WR=1 and RF_ADDR_WR<DEPTH, entry[RF_ADDR_WR] <= RF_DIN at the rising edge.
  - In CLEAR, RF_WR is ignored and the write is lost. There is no queueing, so the master must wait for RF_BUSY=0.
  - With ZERO_R0=1, writes to address 0 are discarded.
- Read path:
  - RF_DX_OUT = entry[RF_ADDRX] combinationally, registered contents only. RF_DY_OUT likewise for RF_ADDRY.
  - Address >= DEPTH reads 0.
  - With ZERO_R0=1, address 0 reads 0.
  - During CLEAR, both outputs are forced to 0 regardless of address.
  - Out of reset, every output is therefore 0 (RF_BUSY=1).
- Bypass (BYPASS=1 only):
  - In IDLE with RF_WR=1 and a valid, non-discarded write address equal to a read address, that read port returns RF_DIN in the same cycle.
  - Both ports may bypass simultaneously.
  - No bypass occurs for an out-of-range or ZERO_R0-discarded write, nor during CLEAR.
- BYPASS=0: a read of the address being written shows the old value until after the edge.
- Arithmetic:
  - Sweep index is ADDR_W bits wide and compared against DEPTH-1; it never wraps past DEPTH.
  - No width conversion on data.
- Memory storage has no dependence on simulation-only initialisation. Contents are defined solely by the sweep, so the block synthesises as a register array without initial values.

Test Plan:
- Reset sweep (DEPTH=32): pulse RF_RST 1 cycle -> RF_BUSY=1 for exactly 32 cycles then 0. Any read then returns 0x00, and a write attempted mid-sweep (addr 5, 0xAA) leaves entry 5 = 0x00.
- Basic R/W (BYPASS=0): write 0x3C to addr 7 -> RF_DX_OUT with ADDRX=7 shows 0x00 in the write cycle and 0x3C the next cycle. RF_DY_OUT with ADDRY=7 also shows 0x3C.
- Bypass (BYPASS=1): write 0x5A to addr 9 with ADDRX=ADDRY=9 -> both outputs show 0x5A in the same cycle as RF_WR. With RF_BUSY=1, the same stimulus gives 0x00.
- Non-power-of-two (DEPTH=20, ADDR_W=5): write 0xFF to addr 25 -> ignored, and a read of 25 returns 0x00. Sweep length is 20 cycles.
- ZERO_R0=1: write 0x11 to addr 0 -> read of 0 returns 0x00; a write of 0x11 to addr 1 reads back 0x11.
- Clear/reset interaction: fill entries with 0xA5, assert RF_CLR, then at sweep cycle 10 assert RF_CLR again (no effect), then at cycle 15 assert RF_RST -> sweep restarts, RF_BUSY stays high for 32 cycles after RF_RST deasserts, and all entries read 0x00 afterwards.

Source files
------------

// File: rtl/rf_param_sweep_if.sv
// rtl/rf_param_sweep_if.sv - register file command/read bus
interface rf_param_sweep_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              RF_CLR;
  logic [ADDR_W-1:0] RF_ADDRX;
  logic [ADDR_W-1:0] RF_ADDRY;
  logic [ADDR_W-1:0] RF_ADDR_WR;
  logic              RF_WR;
  logic [DATA_W-1:0] RF_DIN;
  logic [DATA_W-1:0] RF_DX_OUT;
  logic [DATA_W-1:0] RF_DY_OUT;
  logic              RF_BUSY;

  modport master (
    output RF_CLR, RF_ADDRX, RF_ADDRY, RF_ADDR_WR, RF_WR, RF_DIN,
    input  RF_DX_OUT, RF_DY_OUT, RF_BUSY
  );

  modport slave (
    input  RF_CLR, RF_ADDRX, RF_ADDRY, RF_ADDR_WR, RF_WR, RF_DIN,
    output RF_DX_OUT, RF_DY_OUT, RF_BUSY
  );
endinterface

// File: rtl/rf_param_sweep.sv
// rtl/rf_param_sweep.sv - parametrised 2R/1W register file with clear sweeper
module rf_param_sweep #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int BYPASS  = 0,
  parameter int ZERO_R0 = 0
) (
  input logic RF_CLK,
  input logic RF_RST,
  rf_param_sweep_if.slave rf_bus
);
  typedef enum logic {IDLE, CLEAR} state_t;

  // One extra bit so DEPTH=2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_ok;
  logic x_ok;
  logic y_ok;

  always_ff @(posedge RF_CLK) begin
    if (RF_RST) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rf_bus.RF_CLR) begin
            state <= CLEAR;
            idx   <= '0;
          end
        end
        CLEAR: begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge RF_CLK) begin
    if (!RF_RST) begin
      if (state == CLEAR) begin
        mem[idx] <= '0;
      end else if (wr_ok) begin
        mem[rf_bus.RF_ADDR_WR] <= rf_bus.RF_DIN;
      end
    end
  end

  always_comb begin
    wr_ok = (state == IDLE) && rf_bus.RF_WR
            && ({1'b0, rf_bus.RF_ADDR_WR} < DEPTH_W)
            && !((ZERO_R0 != 0) && (rf_bus.RF_ADDR_WR == '0));
    x_ok  = ({1'b0, rf_bus.RF_ADDRX} < DEPTH_W)
            && !((ZERO_R0 != 0) && (rf_bus.RF_ADDRX == '0));
    y_ok  = ({1'b0, rf_bus.RF_ADDRY} < DEPTH_W)
            && !((ZERO_R0 != 0) && (rf_bus.RF_ADDRY == '0));
  end

  // wr_ok already excludes CLEAR, so the bypass cannot leak data mid-sweep.
  always_comb begin
    rf_bus.RF_DX_OUT = '0;
    rf_bus.RF_DY_OUT = '0;
    if (state == IDLE) begin
      if ((BYPASS != 0) && wr_ok && (rf_bus.RF_ADDR_WR == rf_bus.RF_ADDRX)) begin
        rf_bus.RF_DX_OUT = rf_bus.RF_DIN;
      end else if (x_ok) begin
        rf_bus.RF_DX_OUT = mem[rf_bus.RF_ADDRX];
      end
      if ((BYPASS != 0) && wr_ok && (rf_bus.RF_ADDR_WR == rf_bus.RF_ADDRY)) begin
        rf_bus.RF_DY_OUT = rf_bus.RF_DIN;
      end else if (y_ok) begin
        rf_bus.RF_DY_OUT = mem[rf_bus.RF_ADDRY];
      end
    end
  end

  assign rf_bus.RF_BUSY = (state == CLEAR);
endmodule

// File: tb/tb_rf_param_sweep.sv
// tb/tb_rf_param_sweep.sv - bench for rf_param_sweep, two configurations in lockstep
module tb_rf_param_sweep;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       wr = 1'b0;
  logic [4:0] addrx = '0;
  logic [4:0] addry = '0;
  logic [4:0] addr_wr = '0;
  logic [7:0] din = '0;

  int n_asrt = 0;
  int n_fail = 0;

  // Configuration 0: DEPTH 32, no bypass. Configuration 1: DEPTH 20, bypass, zero entry 0.
  int depth [2] = '{32, 20};
  bit byp   [2] = '{1'b0, 1'b1};
  bit z0    [2] = '{1'b0, 1'b1};

  logic [7:0] mem_m [2][32];
  int         busy_left [2];
  int         busy_cnt [2];

  logic [7:0] dx_o [2];
  logic [7:0] dy_o [2];
  logic       busy_o [2];

  rf_param_sweep_if #(.DATA_W(8), .ADDR_W(5)) bus_a ();
  rf_param_sweep_if #(.DATA_W(8), .ADDR_W(5)) bus_b ();

  rf_param_sweep #(.DATA_W(8), .DEPTH(32), .ADDR_W(5), .BYPASS(0), .ZERO_R0(0)) dut_a (
    .RF_CLK(clk), .RF_RST(rst), .rf_bus(bus_a)
  );
  rf_param_sweep #(.DATA_W(8), .DEPTH(20), .ADDR_W(5), .BYPASS(1), .ZERO_R0(1)) dut_b (
    .RF_CLK(clk), .RF_RST(rst), .rf_bus(bus_b)
  );

  assign bus_a.RF_CLR = clr;      assign bus_b.RF_CLR = clr;
  assign bus_a.RF_ADDRX = addrx;  assign bus_b.RF_ADDRX = addrx;
  assign bus_a.RF_ADDRY = addry;  assign bus_b.RF_ADDRY = addry;
  assign bus_a.RF_ADDR_WR = addr_wr; assign bus_b.RF_ADDR_WR = addr_wr;
  assign bus_a.RF_WR = wr;        assign bus_b.RF_WR = wr;
  assign bus_a.RF_DIN = din;      assign bus_b.RF_DIN = din;

  assign dx_o[0] = bus_a.RF_DX_OUT;  assign dx_o[1] = bus_b.RF_DX_OUT;
  assign dy_o[0] = bus_a.RF_DY_OUT;  assign dy_o[1] = bus_b.RF_DY_OUT;
  assign busy_o[0] = bus_a.RF_BUSY;  assign busy_o[1] = bus_b.RF_BUSY;

  always #5 clk = ~clk;

  function automatic bit write_lands(int d);
    return wr && (int'(addr_wr) < depth[d]) && !(z0[d] && addr_wr == 5'd0);
  endfunction

  function automatic logic [7:0] exp_rd(int d, logic [4:0] a);
    if (busy_left[d] > 0) return 8'h00;
    if (byp[d] && write_lands(d) && addr_wr == a) return din;
    if (int'(a) >= depth[d] || (z0[d] && a == 5'd0)) return 8'h00;
    return mem_m[d][a];
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A sweep is invisible while running, so the model simply zeroes everything when it ends.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        busy_left[d] = depth[d];
      end else if (busy_left[d] > 0) begin
        busy_left[d]--;
        if (busy_left[d] == 0)
          for (int i = 0; i < 32; i++) mem_m[d][i] = 8'h00;
      end else begin
        if (write_lands(d)) mem_m[d][addr_wr] = din;
        if (clr) busy_left[d] = depth[d];
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dx%0d_a%0d", d, addrx), dx_o[d], exp_rd(d, addrx));
      chk($sformatf("dy%0d_a%0d", d, addry), dy_o[d], exp_rd(d, addry));
      chk($sformatf("busy%0d", d), {7'd0, busy_o[d]}, {7'd0, busy_left[d] > 0});
      busy_cnt[d] += int'(busy_o[d]);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs(bit allow_clr);
    addrx   = 5'($urandom_range(0, 31));
    addry   = 5'($urandom_range(0, 31));
    addr_wr = ($urandom_range(0, 3) == 0) ? addrx : 5'($urandom_range(0, 31));
    din     = 8'($urandom);
    wr      = ($urandom_range(0, 1) == 1);
    clr     = allow_clr && ($urandom_range(0, 39) == 0);
  endtask

  task automatic count_sweep(string tag);
    busy_cnt[0] = 0;
    busy_cnt[1] = 0;
    for (int i = 0; i < 40; i++) begin
      rand_inputs(1'b0);
      cyc();
    end
    chk({tag, "_len32"}, 8'(busy_cnt[0]), 8'd32);
    chk({tag, "_len20"}, 8'(busy_cnt[1]), 8'd20);
  endtask

  initial begin
    busy_left[0] = 32;
    busy_left[1] = 20;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) mem_m[d][i] = 8'h00;
    @(posedge clk);
    #1;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset sweep, with a write to entry 5 lost mid-sweep.
    busy_cnt[0] = 0;
    busy_cnt[1] = 0;
    for (int i = 0; i < 40; i++) begin
      rand_inputs(1'b0);
      if (i == 5) begin
        wr = 1'b1; addr_wr = 5'd5; din = 8'hAA;
      end
      cyc();
    end
    chk("reset_len32", 8'(busy_cnt[0]), 8'd32);
    chk("reset_len20", 8'(busy_cnt[1]), 8'd20);
    wr = 1'b0; addrx = 5'd5; addry = 5'd5;
    cyc();

    // Basic write / read at 7, then bypass at 9 on both ports.
    wr = 1'b1; addr_wr = 5'd7; din = 8'h3C; addrx = 5'd7; addry = 5'd7;
    cyc();
    wr = 1'b0;
    cyc();
    wr = 1'b1; addr_wr = 5'd9; din = 8'h5A; addrx = 5'd9; addry = 5'd9;
    cyc();
    wr = 1'b0;
    cyc();

    // Out-of-range for DEPTH 20 at 25; entry 0 discarded vs entry 1 kept.
    wr = 1'b1; addr_wr = 5'd25; din = 8'hFF; addrx = 5'd25; addry = 5'd25;
    cyc();
    wr = 1'b0;
    cyc();
    wr = 1'b1; addr_wr = 5'd0; din = 8'h11; addrx = 5'd0; addry = 5'd1;
    cyc();
    addr_wr = 5'd1;
    cyc();
    wr = 1'b0;
    cyc();

    for (int i = 0; i < 300; i++) begin
      rand_inputs(1'b1);
      cyc();
    end
    clr = 1'b0; wr = 1'b0;
    for (int i = 0; i < 40; i++) cyc();

    // Clear/reset interaction after filling with A5.
    for (int a = 0; a < 32; a++) begin
      wr = 1'b1; addr_wr = 5'(a); din = 8'hA5; addrx = 5'(a); addry = 5'(31 - a);
      cyc();
    end
    wr = 1'b0;
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rand_inputs(1'b0);
      if (i == 3) begin
        wr = 1'b1; addr_wr = 5'd9; din = 8'h5A; addrx = 5'd9; addry = 5'd9;
      end
      cyc();
    end
    wr = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    count_sweep("clr_rst");
    wr = 1'b0;
    for (int a = 0; a < 32; a++) begin
      addrx = 5'(a); addry = 5'(31 - a);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
